// File: rtl/ftf_decoder_25.sv
// ftf_decoder_25
// Receive side of the 25-wire forbidden-transition-free bus. A captured
// codeword is turned back into the data word it encodes, by adding the
// Fibonacci weights of its set bits, BITS_PER_CYCLE bits per clock.
//
// Weights: bit 0 -> 1, bit i (1..24) -> F(i+1), where F(1) = F(2) = 1.
// Legal codewords sum to at most F(26)-1 = 121392, so the result needs
// FBLEN25 = 17 bits. Codewords that are not legal are not flagged; their
// sum simply wraps modulo 2^17.
//
// Ports
//   clock      in   single clock, posedge
//   reset      in   asynchronous, active-high
//   code_in    in   [24:0] codeword, bit 24 carries the largest weight
//   in_valid   in   code_in valid
//   in_ready   out  registered, decoder can take a codeword
//   data_out   out  [FBLEN25-1:0] decoded word, meaningful while out_valid
//   out_valid  out  data_out valid
//   out_ready  in   consumer takes data_out
//
// state | meaning
// IDLE  | waiting for a codeword, in_ready high once out of reset
// ACCUM | adding one group of latched bits per clock
// DONE  | result presented, held until out_ready

module ftf_decoder_25 #(
   parameter  int BITS_PER_CYCLE = 5,
   localparam int FBLEN25        = 17
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [24:0]        code_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [FBLEN25-1:0] data_out,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int         N_GROUPS = 25 / BITS_PER_CYCLE;
   localparam logic [4:0] LAST_IDX = 5'(N_GROUPS - 1);
   localparam logic [4:0] BPC5     = 5'(BITS_PER_CYCLE);

   function automatic logic [24:0][FBLEN25-1:0] build_weights();
      logic [24:0][FBLEN25-1:0] w;
      logic [FBLEN25-1:0]       f_prev;
      logic [FBLEN25-1:0]       f_cur;
      logic [FBLEN25-1:0]       f_next;
      w      = '0;
      w[0]   = FBLEN25'(1);
      f_prev = FBLEN25'(1);
      f_cur  = FBLEN25'(1);
      for (int i = 1; i < 25; i++) begin
         w[i]   = f_cur;
         f_next = f_prev + f_cur;
         f_prev = f_cur;
         f_cur  = f_next;
      end
      return w;
   endfunction

   localparam logic [24:0][FBLEN25-1:0] WEIGHTS = build_weights();

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [24:0]        code_q;
   logic [FBLEN25-1:0] acc;
   logic [4:0]         idx;
   logic [FBLEN25-1:0] group_sum;
   logic [FBLEN25-1:0] acc_next;
   logic [4:0]         bit_idx;

   // Weighted sum of the current group; the weight table is a constant ROM
   // selected by the group index.
   always_comb begin
      group_sum = '0;
      bit_idx   = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         bit_idx = idx * BPC5 + 5'(j);
         if (code_q[bit_idx]) begin
            group_sum = group_sum + WEIGHTS[bit_idx];
         end
      end
   end

   assign acc_next = acc + group_sum;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
         acc       <= '0;
         idx       <= '0;
         code_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_ready && in_valid) begin
                  code_q   <= code_in;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ACCUM;
               end else begin
                  // first edge after reset release raises in_ready
                  in_ready <= 1'b1;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 5'd1;
               if (idx == LAST_IDX) begin
                  data_out  <= acc_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ftf_decoder_25.sv
// Bench for ftf_decoder_25: drivers push expected words into per-DUT queues,
// a negedge monitor pops and compares on every consumed output and checks
// the acceptance-to-out_valid latency. Three instances cover BPC = 5, 1, 25.

module tb_ftf_decoder_25;

   localparam int FNS02 = 1;
   localparam int FNS25 = 75025;
   localparam int FNS26 = 121393;

   logic        clock = 1'b0;
   logic        reset;
   logic [24:0] code_in;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] data_out;
   logic        out_valid;
   logic        out_ready;

   logic [24:0] code1, code25;
   logic        valid1, valid25, ready1, ready25, ov1, ov25;
   logic [16:0] data1, data25;
   logic        one = 1'b1;

   always #5 clock = ~clock;

   ftf_decoder_25 #(.BITS_PER_CYCLE(5)) dut (
      .clock(clock), .reset(reset), .code_in(code_in), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready));

   ftf_decoder_25 #(.BITS_PER_CYCLE(1)) dut1 (
      .clock(clock), .reset(reset), .code_in(code1), .in_valid(valid1),
      .in_ready(ready1), .data_out(data1), .out_valid(ov1),
      .out_ready(one));

   ftf_decoder_25 #(.BITS_PER_CYCLE(25)) dut25 (
      .clock(clock), .reset(reset), .code_in(code25), .in_valid(valid25),
      .in_ready(ready25), .data_out(data25), .out_valid(ov25),
      .out_ready(one));

   typedef struct {
      logic [16:0] data;
      int          accept;
   } exp_t;

   exp_t       sb [3][$];
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   logic [2:0] ovp;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // greedy Fibonacci encoder: any codeword whose weights sum to v decodes to v
   function automatic logic [24:0] ftf_enc(input int v);
      logic [24:0] c;
      int          rem;
      int          w [25];
      c    = '0;
      rem  = v;
      w[0] = 1;
      w[1] = 1;
      for (int i = 2; i < 25; i++) w[i] = w[i-1] + w[i-2];
      for (int i = 24; i >= 1; i--) begin
         if (rem >= w[i]) begin
            c[i] = 1'b1;
            rem  = rem - w[i];
         end
      end
      return c;
   endfunction

   task automatic mon(input int k, input logic ov, input logic ovq, input logic ordy,
                      input logic [16:0] d, input int n);
      exp_t e;
      if (ov && !ovq) begin
         if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid dut%0d: out_valid=1 expected 0 (cycle %0d)", k, cyc);
         end else begin
            check($sformatf("latency_dut%0d", k), cyc - sb[k][0].accept, n);
         end
      end
      if (ov && ordy && sb[k].size() > 0) begin
         e = sb[k].pop_front();
         check($sformatf("data_dut%0d", k), d, e.data);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         mon(0, out_valid, ovp[0], out_ready, data_out, 5);
         mon(1, ov1, ovp[1], 1'b1, data1, 25);
         mon(2, ov25, ovp[2], 1'b1, data25, 1);
      end
      ovp <= {ov25, ov1, out_valid};
   end

   task automatic send(input int k, input logic [24:0] c, input int expd, input bit push);
      logic rdy;
      bit   ok;
      exp_t e;
      ok = 1'b0;
      @(posedge clock);
      #1;
      case (k)
         0:       begin code_in = c; in_valid = 1'b1; end
         1:       begin code1   = c; valid1   = 1'b1; end
         default: begin code25  = c; valid25  = 1'b1; end
      endcase
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clock);
         rdy = (k == 0) ? in_ready : ((k == 1) ? ready1 : ready25);
         if (rdy) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout dut%0d: in_ready=0 expected 1", k);
      end else if (push) begin
         e.data   = 17'(expd);
         e.accept = cyc + 1;
         sb[k].push_back(e);
      end
      @(posedge clock);
      #1;
      case (k)
         0:       in_valid = 1'b0;
         1:       valid1   = 1'b0;
         default: valid25  = 1'b0;
      endcase
   endtask

   task automatic drain();
      for (int t = 0; t < 1000 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++)
         @(negedge clock);
      check("drain_pending", sb[0].size() + sb[1].size() + sb[2].size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  rt [$];
      int  sw [$];
      bit  seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      valid1    = 1'b0;
      valid25   = 1'b0;
      out_ready = 1'b1;
      code_in   = '0;
      code1     = '0;
      code25    = '0;

      // reset state
      repeat (3) begin
         @(negedge clock);
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_data_out", data_out, 0);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("in_ready_before_edge", in_ready, 0);
      @(negedge clock);
      check("in_ready_after_release", in_ready, 1);

      // basic decode, hand-computed weights
      send(0, 25'h0000000, 0, 1);
      send(0, 25'h0000001, 1, 1);
      send(0, 25'h1000000, FNS25, 1);
      send(0, 25'h0000002, FNS02, 1);
      send(0, 25'h0000015, 8, 1);          // 1 + 2 + 5
      send(0, 25'h1FFFFFF, 65345, 1);      // illegal: 196417 mod 2^17
      drain();

      // backpressure
      out_ready = 1'b0;
      send(0, 25'h0000100, 34, 1);         // bit 8 -> F(9)
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clock);
         if (out_valid) seen = 1'b1;
      end
      check("bp_out_valid_rise", seen, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_data_out", data_out, 34);
         check("bp_in_ready", in_ready, 0);
         @(posedge clock);
         #1;
         code_in  = 25'h0000001;
         in_valid = (i == 2 || i == 4);
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      code_in   = 25'h0000004;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      check("bp_in_ready_before_consume", in_ready, 0);
      @(negedge clock);
      check("bp_in_ready_after_consume", in_ready, 1);
      begin
         exp_t e;
         e.data   = 17'd2;
         e.accept = cyc + 1;
         sb[0].push_back(e);
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
      drain();

      // reset after the second accumulation edge
      send(0, 25'h0000003, 0, 0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("abort_in_ready", in_ready, 0);
         check("abort_out_valid", out_valid, 0);
         check("abort_data_out", data_out, 0);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_in_ready_before_edge", in_ready, 0);
      @(negedge clock);
      check("abort_in_ready_after_release", in_ready, 1);
      repeat (6) @(negedge clock);
      check("abort_no_out_valid", out_valid, 0);
      send(0, 25'h1000001, FNS25 + 1, 1);
      drain();

      // round trip through the encoder model
      rt = '{0, 1, FNS25 - 1, FNS25, FNS26 - 1};
      foreach (rt[i]) send(0, ftf_enc(rt[i]), rt[i], 1);
      for (int i = 0; i < 2000; i++) begin
         int v;
         v = int'($urandom_range(FNS26 - 1, 0));
         send(0, ftf_enc(v), v, 1);
      end
      drain();

      // BPC = 1 and BPC = 25 on the round-trip vector set
      sw = rt;
      for (int i = 0; i < 20; i++) sw.push_back(int'($urandom_range(FNS26 - 1, 0)));
      fork
         begin
            for (int i = 0; i < sw.size(); i++) send(1, ftf_enc(sw[i]), sw[i], 1);
         end
         begin
            for (int j = 0; j < sw.size(); j++) send(2, ftf_enc(sw[j]), sw[j], 1);
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
